// File: rtl/hilo_muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op-select encodings,
// FSM state encoding, default iteration count and small helper functions.
package hilo_muldiv_pkg;

  // Default number of iterations (one operand bit per cycle)
  localparam int HILO_ITER = 32;

  // One-hot mul_control encodings produced by the decoder
  localparam logic [3:0] mult_mc  = 4'b0001;
  localparam logic [3:0] multu_mc = 4'b0010;
  localparam logic [3:0] div_mc   = 4'b0100;
  localparam logic [3:0] divu_mc  = 4'b1000;

  // FSM state encoding
  typedef enum logic [1:0] {
    HILO_IDLE = 2'd0,
    HILO_RUN  = 2'd1,
    HILO_FIX  = 2'd2
  } hilo_state_e;

  // True only for one of the four legal one-hot op selects
  function automatic logic mc_valid(input logic [3:0] mc);
    return (mc == mult_mc) || (mc == multu_mc) ||
           (mc == div_mc)  || (mc == divu_mc);
  endfunction

  // Absolute value of a two's-complement word when neg is set
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/hilo_muldiv_muldiv_step.sv
// muldiv_step: one combinational iteration of the iterative mul/div datapath.
// The accumulator is a {hi, lo} register pair:
//   multiply: hi = partial product, lo = remaining multiplier bits,
//             op = multiplicand; one shift-add step, shifting right.
//   divide:   hi = partial remainder, lo = dividend bits / quotient bits,
//             op = divisor; one restoring trial-subtract step, shifting left.
module muldiv_step
  import hilo_muldiv_pkg::*;
(
  input  logic        i_is_div,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  input  logic [31:0] i_op,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  logic [32:0] w_sum;
  logic [32:0] w_shift;
  logic [31:0] w_diff;
  logic        w_ge;

  // Select between the shift-add step and the restoring subtract step
  always_comb begin
    w_sum   = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_op} : 33'd0);
    w_shift = {i_hi, i_lo[31]};
    w_ge    = (w_shift >= {1'b0, i_op});
    // When w_ge holds the true difference is below 2^32, so the low word is exact
    w_diff  = w_shift[31:0] - i_op;
    o_hi    = w_sum[32:1];
    o_lo    = {w_sum[0], i_lo[31:1]};
    if (i_is_div) begin
      if (w_ge) begin
        o_hi = w_diff;
        o_lo = {i_lo[30:0], 1'b1};
      end else begin
        o_hi = w_shift[31:0];
        o_lo = {i_lo[30:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Operates on unsigned magnitudes for ITER cycles, then applies sign
// correction in a single FIX cycle and writes HI/LO.
// Optional build macro HILO_FAST_MUL_EN: multiplies use a single-cycle
// multiplier (IDLE->FIX->IDLE); divides stay iterative.
//
// Handshake: an op is accepted at a rising edge where start=1, busy=0 and
// mul_control is one of the four legal one-hot values; any other start is
// dropped. busy stays high while the op is in flight, and done pulses for
// exactly one cycle when the new HI/LO values are visible. start may be
// reasserted in the done cycle. MTHI/MTLO or flush abort an in-flight op
// (no done pulse).
module hilo_muldiv
  import hilo_muldiv_pkg::*;
#(
  parameter int ITER = HILO_ITER
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  mul_control,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        hi_wen,
  input  logic        lo_wen,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [1:0]  o_dbg_state
);

  localparam int            CW   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  // Architectural and control registers
  hilo_state_e   r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;
  logic          r_done;

  // Datapath registers latched at issue
  logic [31:0]   r_acc_hi;
  logic [31:0]   r_acc_lo;
  logic [31:0]   r_op;
  logic [31:0]   r_a_raw;
  logic          r_is_div;
  logic          r_neg_q;
  logic          r_neg_r;
  logic          r_div_zero;
`ifdef HILO_FAST_MUL_EN
  logic          r_fast;
`endif

  // Issue-time decode
  logic          w_launch;
  logic          w_is_div;
  logic          w_signed;
  logic          w_a_neg;
  logic          w_b_neg;
  logic [31:0]   w_a_mag;
  logic [31:0]   w_b_mag;

  // Iteration step and writeback values
  logic [31:0]   w_step_hi;
  logic [31:0]   w_step_lo;
  logic [63:0]   w_mag64;
  logic [63:0]   w_prod;
  logic [31:0]   w_quo;
  logic [31:0]   w_rem;
  logic [31:0]   w_res_hi;
  logic [31:0]   w_res_lo;

  assign busy        = (r_state != HILO_IDLE);
  assign done        = r_done;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign o_dbg_state = r_state;

  // Decode the incoming op and take operand magnitudes for the signed forms
  always_comb begin
    w_launch = start && mc_valid(mul_control) && (r_state == HILO_IDLE);
    w_is_div = mul_control[2] | mul_control[3];
    w_signed = mul_control[0] | mul_control[2];
    w_a_neg  = w_signed & src_a[31];
    w_b_neg  = w_signed & src_b[31];
    w_a_mag  = mag32(src_a, w_a_neg);
    w_b_mag  = mag32(src_b, w_b_neg);
  end

  muldiv_step u_step (
    .i_is_div (r_is_div),
    .i_hi     (r_acc_hi),
    .i_lo     (r_acc_lo),
    .i_op     (r_op),
    .o_hi     (w_step_hi),
    .o_lo     (w_step_lo)
  );

  // Sign-correct the unsigned result into the final HI/LO values
  always_comb begin
`ifdef HILO_FAST_MUL_EN
    w_mag64 = r_fast ? ({32'd0, r_op} * {32'd0, r_acc_lo}) : {r_acc_hi, r_acc_lo};
`else
    w_mag64 = {r_acc_hi, r_acc_lo};
`endif
    w_prod = r_neg_q ? (~w_mag64 + 64'd1) : w_mag64;
    w_quo  = r_neg_q ? (~r_acc_lo + 32'd1) : r_acc_lo;
    w_rem  = r_neg_r ? (~r_acc_hi + 32'd1) : r_acc_hi;
    if (r_is_div) begin
      if (r_div_zero) begin
        // Divide by zero returns the raw dividend and an all-ones quotient
        w_res_hi = r_a_raw;
        w_res_lo = 32'hFFFF_FFFF;
      end else begin
        w_res_hi = w_rem;
        w_res_lo = w_quo;
      end
    end else begin
      w_res_hi = w_prod[63:32];
      w_res_lo = w_prod[31:0];
    end
  end

  // Control FSM, HI/LO registers and iterative datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= HILO_IDLE;
      r_cnt      <= '0;
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
      r_done     <= 1'b0;
      r_acc_hi   <= 32'd0;
      r_acc_lo   <= 32'd0;
      r_op       <= 32'd0;
      r_a_raw    <= 32'd0;
      r_is_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
`ifdef HILO_FAST_MUL_EN
      r_fast     <= 1'b0;
`endif
    end else if (flush) begin
      // Flush wins over everything but reset; HI/LO keep their values
      r_state <= HILO_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (hi_wen) r_hi <= wdata;
      if (lo_wen) r_lo <= wdata;
      if ((hi_wen || lo_wen) && (r_state != HILO_IDLE)) begin
        // MTHI/MTLO abort an in-flight op; no writeback, no done
        r_state <= HILO_IDLE;
      end else begin
        case (r_state)
          HILO_IDLE: begin
            if (w_launch) begin
              r_cnt      <= '0;
              r_is_div   <= w_is_div;
              r_neg_q    <= w_a_neg ^ w_b_neg;
              r_neg_r    <= w_a_neg;
              r_div_zero <= w_is_div && (src_b == 32'd0);
              r_a_raw    <= src_a;
              r_acc_hi   <= 32'd0;
              r_acc_lo   <= w_is_div ? w_a_mag : w_b_mag;
              r_op       <= w_is_div ? w_b_mag : w_a_mag;
`ifdef HILO_FAST_MUL_EN
              r_fast     <= !w_is_div;
              r_state    <= w_is_div ? HILO_RUN : HILO_FIX;
`else
              r_state    <= HILO_RUN;
`endif
            end
          end
          HILO_RUN: begin
            r_acc_hi <= w_step_hi;
            r_acc_lo <= w_step_lo;
            r_cnt    <= r_cnt + CW'(1);
            if (r_cnt == LAST) r_state <= HILO_FIX;
          end
          HILO_FIX: begin
            r_hi    <= w_res_hi;
            r_lo    <= w_res_lo;
            r_done  <= 1'b1;
            r_state <= HILO_IDLE;
          end
          default: r_state <= HILO_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Testbench for hilo_muldiv: directed vectors with hand-computed HI/LO
// results, a scoreboard queue consumed by a done-driven monitor, plus
// abort, flush, reset and illegal-op scenarios.
module tb_hilo_muldiv;
  import hilo_muldiv_pkg::*;

  localparam int TB_ITER = 32;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  mul_control;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        hi_wen;
  logic        lo_wen;
  logic [31:0] wdata;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [1:0]  o_dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  hilo_muldiv #(.ITER(TB_ITER)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mul_control (mul_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .hi_wen      (hi_wen),
    .lo_wen      (lo_wen),
    .wdata       (wdata),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          total = 0;
  int          bad   = 0;
  logic [63:0] exp_q[$];
  int          lat_q[$];
  int          start_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic int exp_lat(input logic [3:0] mc);
`ifdef HILO_FAST_MUL_EN
    if (mc == mult_mc || mc == multu_mc) return 1;
`endif
    return TB_ITER + 1;
  endfunction

  // Monitor: every done pulse pops one expected result and its latency
  logic [63:0] m_exp;
  int          m_lat;
  int          m_start;
  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got hi=%h lo=%h expected no done (t=%0t)", hi, lo, $time);
      end else begin
        m_exp   = exp_q.pop_front();
        m_lat   = lat_q.pop_front();
        m_start = start_q.pop_front();
        check("result_hilo", {hi, lo}, m_exp);
        check("done_latency", 64'(cyc - m_start), 64'(m_lat));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; the following posedge is the issue edge.
  task automatic issue(input logic [3:0] mc, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] expv, input bit push);
    mul_control = mc;
    src_a       = a;
    src_b       = b;
    start       = 1'b1;
    if (push) begin
      exp_q.push_back(expv);
      lat_q.push_back(exp_lat(mc));
      start_q.push_back(cyc + 1);
    end
    @(negedge clk);
    start       = 1'b0;
    mul_control = 4'b0000;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL wait_idle_timeout: got busy for %0d cycles expected under 200", n);
    end
  endtask

  task automatic run_op(input logic [3:0] mc, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] expv);
    int n;
    issue(mc, a, b, expv, 1'b1);
    wait_idle(n);
    check("busy_cycles", 64'(n), 64'(exp_lat(mc)));
  endtask

  task automatic write_hilo(input logic wh, input logic wl, input logic [31:0] d);
    hi_wen = wh;
    lo_wen = wl;
    wdata  = d;
    @(negedge clk);
    hi_wen = 1'b0;
    lo_wen = 1'b0;
  endtask

  // ---------------- directed vectors ----------------
  logic [3:0]  v_mc [12];
  logic [31:0] v_a  [12];
  logic [31:0] v_b  [12];
  logic [63:0] v_e  [12];

  initial begin
    int n;
    v_mc = '{multu_mc, mult_mc, div_mc, divu_mc, divu_mc, div_mc,
             mult_mc, multu_mc, div_mc, div_mc, div_mc, mult_mc};
    v_a  = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd7, 32'h0000_1234, 32'h8000_0000,
             32'd7, 32'h0001_0000, 32'd7, 32'hFFFF_FFF8, 32'hFFFF_FFF0, 32'h8000_0000};
    v_b  = '{32'hFFFF_FFFF, 32'd5, 32'd2, 32'd2, 32'd0, 32'hFFFF_FFFF,
             32'hFFFF_FFFA, 32'h0001_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd0, 32'h8000_0000};
    v_e  = '{64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFF_FFFF_FFF1,
             64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0001_0000_0003,
             64'h0000_1234_FFFF_FFFF, 64'h0000_0000_8000_0000,
             64'hFFFF_FFFF_FFFF_FFD6, 64'h0000_0001_0000_0000,
             64'h0000_0001_FFFF_FFFD, 64'hFFFF_FFFE_0000_0002,
             64'hFFFF_FFF0_FFFF_FFFF, 64'h4000_0000_0000_0000};

    rst = 1'b1; start = 1'b0; mul_control = 4'b0000; src_a = 32'd0; src_b = 32'd0;
    hi_wen = 1'b0; lo_wen = 1'b0; wdata = 32'd0; flush = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back: each op after the first issues in the previous done cycle
    for (int i = 0; i < 12; i++) begin
      if (i > 0) check("b2b_done_cycle", {63'd0, done}, 64'd1);
      run_op(v_mc[i], v_a[i], v_b[i], v_e[i]);
    end
    repeat (3) @(negedge clk);

    // MTHI together with start while idle: both act, the op result wins
    hi_wen = 1'b1;
    wdata  = 32'hDEAD_BEEF;
    issue(multu_mc, 32'd2, 32'd3, 64'h0000_0000_0000_0006, 1'b1);
    hi_wen = 1'b0;
    check("wen_start_hi", {32'd0, hi}, {32'd0, 32'hDEAD_BEEF});
    check("wen_start_busy", {63'd0, busy}, 64'd1);
    wait_idle(n);
    repeat (2) @(negedge clk);

    // Abort by MTHI at RUN cycle 10
    write_hilo(1'b1, 1'b1, 32'h1111_1111);
    check("preload_hi", {32'd0, hi}, {32'd0, 32'h1111_1111});
    check("preload_lo", {32'd0, lo}, {32'd0, 32'h1111_1111});
    issue(divu_mc, 32'd100, 32'd7, 64'd0, 1'b0);
    repeat (9) @(negedge clk);
    write_hilo(1'b1, 1'b0, 32'hA5A5_A5A5);
    check("abort_hi", {32'd0, hi}, {32'd0, 32'hA5A5_A5A5});
    check("abort_lo", {32'd0, lo}, {32'd0, 32'h1111_1111});
    check("abort_busy", {63'd0, busy}, 64'd0);
    repeat (40) @(negedge clk);

    // Abort by flush at RUN cycle 10
    write_hilo(1'b1, 1'b0, 32'h1111_1111);
    issue(div_mc, 32'hFFFF_FF00, 32'd9, 64'd0, 1'b0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_hi", {32'd0, hi}, {32'd0, 32'h1111_1111});
    check("flush_lo", {32'd0, lo}, {32'd0, 32'h1111_1111});
    check("flush_busy", {63'd0, busy}, 64'd0);
    repeat (40) @(negedge clk);

    // Flush in the same cycle as start: start is dropped
    flush = 1'b1;
    issue(multu_mc, 32'd4, 32'd4, 64'd0, 1'b0);
    flush = 1'b0;
    check("flush_start_busy", {63'd0, busy}, 64'd0);
    repeat (40) @(negedge clk);

    // Reset mid-RUN discards the op and clears HI/LO
    issue(div_mc, 32'd50, 32'd3, 64'd0, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_hi", {32'd0, hi}, 64'd0);
    check("midrst_lo", {32'd0, lo}, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_done", {63'd0, done}, 64'd0);

    // Illegal op selects are ignored
    issue(4'b0011, 32'd1, 32'd1, 64'd0, 1'b0);
    check("nonhot_busy", {63'd0, busy}, 64'd0);
    issue(4'b0000, 32'd1, 32'd1, 64'd0, 1'b0);
    check("zero_mc_busy", {63'd0, busy}, 64'd0);
    repeat (40) @(negedge clk);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
